// File: rtl/prbs_pkg.sv
// Shared definitions for the XNOR-feedback PRBS generator/checker pair:
// checker state encoding and the PRBS7 default polynomial.
package prbs_pkg;

    localparam int         PRBS7_W    = 7;
    localparam logic [6:0] PRBS7_TAPS = 7'h60;   // x^7 + x^6 + 1

    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_LOCKED = 2'b10
    } prbs_state_e;

endpackage

// File: rtl/xnor_prbs_checker_if.sv
// Serial PRBS input and status bundle for xnor_prbs_checker.
// PRBS_CHK_BITCNT_EN adds the 32-bit compared-bit counter.
interface xnor_prbs_checker_if #(
    parameter int ERR_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             in_clear;
    logic             out_locked;
    logic             out_err;
    logic [ERR_W-1:0] out_err_cnt;
    logic [1:0]       out_state;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0]      out_bit_cnt;

    modport master (
        output in_valid, in_bit, in_clear,
        input  out_locked, out_err, out_err_cnt, out_state, out_bit_cnt
    );
    modport slave (
        input  in_valid, in_bit, in_clear,
        output out_locked, out_err, out_err_cnt, out_state, out_bit_cnt
    );
`else
    modport master (
        output in_valid, in_bit, in_clear,
        input  out_locked, out_err, out_err_cnt, out_state
    );
    modport slave (
        input  in_valid, in_bit, in_clear,
        output out_locked, out_err, out_err_cnt, out_state
    );
`endif
endinterface

// File: rtl/prbs_xnor_predict.sv
// Next-bit prediction for an XNOR-feedback LFSR; also flags the all-ones
// lock-up state, which an XNOR LFSR can never leave.
module prbs_xnor_predict #(
    parameter int             W    = 7,
    parameter logic [W-1:0]   TAPS = 7'h60
) (
    input  logic [W-1:0] shreg,
    output logic         pred,
    output logic         all_ones
);

    logic [W-1:0] tapped;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_tap
            assign tapped[gi] = shreg[gi] & TAPS[gi];
        end
    endgenerate

    assign pred     = ~^tapped;
    assign all_ones = &shreg;

endmodule

// File: rtl/xnor_prbs_checker.sv
// Self-synchronising XNOR PRBS checker: fill, search for lock, then count
// bit errors and drop lock on excessive window error density.
// PRBS_CHK_BITCNT_EN adds out_bit_cnt (bits compared while locked).
module xnor_prbs_checker
    import prbs_pkg::*;
#(
    parameter int                LFSR_W   = PRBS7_W,
    parameter logic [LFSR_W-1:0] TAPS     = PRBS7_TAPS,
    parameter int                LOCK_CNT = 16,
    parameter int                WIN      = 64,
    parameter int                LOSS_THR = 8,
    parameter int                ERR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xnor_prbs_checker_if.slave   bus
);

    localparam int FILL_W  = $clog2(LFSR_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN + 1);
    localparam int WERR_W  = $clog2(LOSS_THR + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_W - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN - 1);
    localparam logic [WERR_W-1:0]  LOSS_VAL   = WERR_W'(LOSS_THR);

    prbs_state_e         state_reg;
    logic [LFSR_W-1:0]   shreg_reg;
    logic [FILL_W-1:0]   fill_reg;
    logic [MATCH_W-1:0]  match_reg;
    logic [WIN_W-1:0]    win_reg;
    logic [WERR_W-1:0]   werr_reg;
    logic                locked_reg;
    logic                err_reg;
    logic [ERR_W-1:0]    err_cnt_reg;
    logic [ERR_W-1:0]    err_cnt_next;
    logic [WERR_W-1:0]   werr_next;

    logic pred;
    logic all_ones;
    logic locked_cmp;
    logic mismatch;

    prbs_xnor_predict #(
        .W    (LFSR_W),
        .TAPS (TAPS)
    ) u_predict (
        .shreg    (shreg_reg),
        .pred     (pred),
        .all_ones (all_ones)
    );

    assign locked_cmp = bus.in_valid && (state_reg == ST_LOCKED);
    assign mismatch   = pred != bus.in_bit;
    assign werr_next  = werr_reg + WERR_W'(mismatch);

    // Clear takes effect before the count, so clear + error leaves 1.
    always_comb begin
        err_cnt_next = bus.in_clear ? '0 : err_cnt_reg;
        if (locked_cmp && mismatch && !(&err_cnt_next))
            err_cnt_next = err_cnt_next + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_FILL;
            shreg_reg   <= '0;
            fill_reg    <= '0;
            match_reg   <= '0;
            win_reg     <= '0;
            werr_reg    <= '0;
            locked_reg  <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            err_reg     <= 1'b0;
            err_cnt_reg <= err_cnt_next;
            if (bus.in_valid) begin
                unique case (state_reg)
                    ST_FILL: begin
                        shreg_reg <= {shreg_reg[LFSR_W-2:0], bus.in_bit};
                        if (fill_reg == FILL_LAST) begin
                            fill_reg  <= '0;
                            state_reg <= ST_SEARCH;
                        end else begin
                            fill_reg <= fill_reg + 1'b1;
                        end
                    end
                    ST_SEARCH: begin
                        shreg_reg <= {shreg_reg[LFSR_W-2:0], bus.in_bit};
                        // The all-ones state predicts 1 forever; never count it.
                        if (all_ones || mismatch) begin
                            match_reg <= '0;
                        end else if (match_reg == MATCH_LAST) begin
                            match_reg  <= '0;
                            win_reg    <= '0;
                            werr_reg   <= '0;
                            state_reg  <= ST_LOCKED;
                            locked_reg <= 1'b1;
                        end else begin
                            match_reg <= match_reg + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        shreg_reg <= {shreg_reg[LFSR_W-2:0], pred};
                        err_reg   <= mismatch;
                        if (werr_next == LOSS_VAL) begin
                            state_reg  <= ST_FILL;
                            locked_reg <= 1'b0;
                            fill_reg   <= '0;
                            match_reg  <= '0;
                        end else if (win_reg == WIN_LAST) begin
                            win_reg  <= '0;
                            werr_reg <= '0;
                        end else begin
                            win_reg  <= win_reg + 1'b1;
                            werr_reg <= werr_next;
                        end
                    end
                    default: state_reg <= ST_FILL;
                endcase
            end
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt_reg;
    logic [31:0] bit_cnt_next;

    always_comb begin
        bit_cnt_next = bus.in_clear ? '0 : bit_cnt_reg;
        if (locked_cmp && !(&bit_cnt_next))
            bit_cnt_next = bit_cnt_next + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_cnt_reg <= '0;
        else
            bit_cnt_reg <= bit_cnt_next;
    end

    assign bus.out_bit_cnt = bit_cnt_reg;
`endif

    assign bus.out_state   = state_reg;
    assign bus.out_locked  = locked_reg;
    assign bus.out_err     = err_reg;
    assign bus.out_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_xnor_prbs_checker.sv
// Scoreboard bench for xnor_prbs_checker: PRBS7 XNOR source, behavioural
// reference model, per-cycle expected outputs queued and compared.
module tb_xnor_prbs_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xnor_prbs_checker_if #(.ERR_W(16)) bus ();

    xnor_prbs_checker #(
        .LFSR_W(7), .TAPS(7'h60), .LOCK_CNT(16), .WIN(64), .LOSS_THR(8), .ERR_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        err;
        logic        locked;
        logic [1:0]  state;
        logic [15:0] errcnt;
        logic [31:0] bitcnt;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Source and reference-model state
    logic [6:0] gen_sh;
    logic [6:0] m_sh;
    int         m_state, m_fill, m_match, m_win, m_werr;
    logic       m_err;
    int         m_errcnt;
    longint     m_bitcnt;

    int   bit_idx, lock_rises, lock_falls, err_pulses, last_lock_bit;
    logic prev_locked;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t bit=%0d)", tag, got, exp, $time, bit_idx);
        end
    endtask

    task automatic model_reset();
        m_sh = '0; m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_err = 1'b0; m_errcnt = 0; m_bitcnt = 0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic c);
        logic p;
        p = ~(m_sh[6] ^ m_sh[5]);
        m_err = 1'b0;
        if (c) begin
            m_errcnt = 0;
            m_bitcnt = 0;
        end
        if (!v) return;
        case (m_state)
            0: begin
                m_sh = {m_sh[5:0], b};
                m_fill++;
                if (m_fill == 7) begin m_fill = 0; m_state = 1; end
            end
            1: begin
                if (m_sh == 7'h7f || p != b) m_match = 0;
                else m_match++;
                m_sh = {m_sh[5:0], b};
                if (m_match == 16) begin
                    m_state = 2; m_match = 0; m_win = 0; m_werr = 0;
                end
            end
            default: begin
                m_sh = {m_sh[5:0], p};
                if (m_bitcnt != 64'hffff_ffff) m_bitcnt++;
                m_win++;
                if (p != b) begin
                    m_err = 1'b1;
                    if (m_errcnt != 16'hffff) m_errcnt++;
                    m_werr++;
                end
                if (m_werr == 8) begin
                    m_state = 0; m_fill = 0; m_match = 0;
                end else if (m_win == 64) begin
                    m_win = 0; m_werr = 0;
                end
            end
        endcase
    endtask

    // One cycle: drive at negedge, push model prediction, compare 1 ns after posedge.
    task automatic send(input logic v, input logic flip, input logic clr, input logic stuck);
        logic b, pb;
        exp_t e;
        @(negedge clk);
        b = 1'b0;
        if (v) begin
            bit_idx++;
            pb = ~(gen_sh[6] ^ gen_sh[5]);
            gen_sh = {gen_sh[5:0], pb};
            b = (stuck ? 1'b1 : pb) ^ flip;
        end
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.in_clear = clr;
        model_step(v, b, clr);
        e.err = m_err; e.locked = (m_state == 2); e.state = 2'(m_state);
        e.errcnt = 16'(m_errcnt); e.bitcnt = 32'(m_bitcnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("out_err",     32'(bus.out_err),     32'(e.err));
        check_eq("out_locked",  32'(bus.out_locked),  32'(e.locked));
        check_eq("out_state",   32'(bus.out_state),   32'(e.state));
        check_eq("out_err_cnt", 32'(bus.out_err_cnt), 32'(e.errcnt));
`ifdef PRBS_CHK_BITCNT_EN
        check_eq("out_bit_cnt", bus.out_bit_cnt, e.bitcnt);
`endif
        if (bus.out_locked && !prev_locked) begin lock_rises++; last_lock_bit = bit_idx; end
        if (!bus.out_locked && prev_locked) lock_falls++;
        if (bus.out_err) err_pulses++;
        prev_locked = bus.out_locked;
        bus.in_clear = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_locked"}, 32'(bus.out_locked),  32'd0);
        check_eq({tag, "_err"},    32'(bus.out_err),     32'd0);
        check_eq({tag, "_cnt"},    32'(bus.out_err_cnt), 32'd0);
        check_eq({tag, "_state"},  32'(bus.out_state),   32'd0);
`ifdef PRBS_CHK_BITCNT_EN
        check_eq({tag, "_bits"},   bus.out_bit_cnt,      32'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_clear = 1'b0;
        model_reset();
        sb_q.delete();
        gen_sh = '0; bit_idx = 0; lock_rises = 0; lock_falls = 0;
        err_pulses = 0; last_lock_bit = 0; prev_locked = 1'b0;
        #1;
        check_zero_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_clear = 1'b0;
        gen_sh = '0;
        model_reset();

        // Clean PRBS7 stream: lock on bit 23, no errors over 1000 bits
        do_reset();
        for (int i = 1; i <= 1000; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("clean_lock_bit", 32'(last_lock_bit), 32'd23);
        check_eq("clean_locked",   32'(bus.out_locked), 32'd1);
        check_eq("clean_err_cnt",  32'(bus.out_err_cnt), 32'd0);
        $display("clean stream: lock at bit %0d, err_cnt %0d", last_lock_bit, bus.out_err_cnt);

        // Single flipped bit
        do_reset();
        for (int i = 1; i <= 200; i++) send(1'b1, i == 100, 1'b0, 1'b0);
        check_eq("single_pulses",  32'(err_pulses), 32'd1);
        check_eq("single_err_cnt", 32'(bus.out_err_cnt), 32'd1);
        check_eq("single_falls",   32'(lock_falls), 32'd0);
        $display("single error: pulses %0d err_cnt %0d", err_pulses, bus.out_err_cnt);

        // Eight errors in one window: loss after bit 37, relock 23 bits later
        do_reset();
        for (int i = 1; i <= 37; i++) send(1'b1, i >= 30, 1'b0, 1'b0);
        check_eq("loss_locked", 32'(bus.out_locked), 32'd0);
        check_eq("loss_state",  32'(bus.out_state),  32'd0);
        for (int i = 38; i <= 100; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("relock_bit",     32'(last_lock_bit), 32'd60);
        check_eq("loss_err_cnt",   32'(bus.out_err_cnt), 32'd8);
        $display("loss: relock at bit %0d", last_lock_bit);

        // Seven errors per window for ten windows: lock held
        do_reset();
        for (int i = 1; i <= 23 + 640 + 10; i++) begin
            int off;
            off = i - 24;
            send(1'b1, (i >= 24) && (i < 24 + 640) && ((off % 64) % 9 == 0) && ((off % 64) <= 54),
                 1'b0, 1'b0);
        end
        check_eq("win7_err_cnt", 32'(bus.out_err_cnt), 32'd70);
        check_eq("win7_falls",   32'(lock_falls), 32'd0);
        check_eq("win7_locked",  32'(bus.out_locked), 32'd1);
        $display("7 per window: err_cnt %0d falls %0d", bus.out_err_cnt, lock_falls);

        // Stuck-at-1 input never locks
        do_reset();
        for (int i = 1; i <= 500; i++) begin
            send(1'b1, 1'b0, 1'b0, 1'b1);
            if (i == 7) check_eq("stuck_state7", 32'(bus.out_state), 32'd1);
        end
        check_eq("stuck_rises", 32'(lock_rises), 32'd0);
        check_eq("stuck_state", 32'(bus.out_state), 32'd1);
        $display("stuck-at-1: lock rises %0d state %0d", lock_rises, bus.out_state);

        // Clear coinciding with an error leaves a count of one
        do_reset();
        for (int i = 1; i <= 60; i++) send(1'b1, (i == 30) || (i == 40), i == 40, 1'b0);
        check_eq("clear_err_cnt", 32'(bus.out_err_cnt), 32'd1);
        $display("clear with error: err_cnt %0d", bus.out_err_cnt);

        // Asynchronous reset mid-stream after a counted error
        do_reset();
        for (int i = 1; i <= 50; i++) send(1'b1, i == 40, 1'b0, 1'b0);
        check_eq("pre_rst_locked", 32'(bus.out_locked), 32'd1);
        check_eq("pre_rst_cnt",    32'(bus.out_err_cnt), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        $display("async reset: outputs cleared");

        // in_valid toggling: same lock point in valid bits
        do_reset();
        for (int i = 0; i < 80; i++) begin
            send(1'b1, 1'b0, 1'b0, 1'b0);
            send(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("gap_lock_bit", 32'(last_lock_bit), 32'd23);
        $display("gapped valid: lock at bit %0d", last_lock_bit);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
